// File: rtl/lab1_pkg.sv
// Shared types and helpers for the lab1 display path.
// Holds the BCD converter state type and its sizing check.
package lab1_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

    // Decimal digits needed to show the largest WIDTH-bit value.
    function automatic int bcd_digits_needed(input int width);
        longint unsigned v;
        int n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            v = v / 64'd10;
            if (v != 0) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake bundle for the sequential BCD converter.
// The master issues conversions, the slave returns digits.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank
    );
endinterface

// File: rtl/bcd_add3.sv
// Per-digit double-dabble adjust: add 3 when the digit is 5 or more.
// No carry out; the digit count guarantees it never overflows.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj
);
    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter feeding the 7-segment decoders.
// One input bit per cycle; outputs hold until the next conversion.
module bin2bcd_seq
    import lab1_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    generate
        if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_size_chk
            $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    b2b_state_t state_q, state_d;

    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    sh_q;
    logic [4*DIGITS-1:0] scr_q;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blank_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load, shift, fin;
    logic                zero_run;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        fin   = 1'b0;
        unique case (1'b1)
            state_q == IDLE:  load  = bus.start;
            state_q == SHIFT: shift = 1'b1;
            state_q == DONE:  fin   = 1'b1;
            default: ;
        endcase
        busy_d = load | shift;
        done_d = fin;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_add
        bcd_add3 u_add3 (
            .digit (scr_q[4*i +: 4]),
            .adj   (adj[4*i +: 4])
        );
    end

    // Blank a digit only while every digit above it is also zero.
    always_comb begin
        zero_run = 1'b1;
        blank_d  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (scr_q[4*i +: 4] == 4'd0);
            blank_d[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (load) begin
                sh_q  <= bus.bin;
                scr_q <= '0;
                cnt_q <= CW'(WIDTH);
            end else if (shift) begin
                {scr_q, sh_q} <= {adj, sh_q} << 1;
                cnt_q         <= cnt_q - CW'(1);
            end else if (fin) begin
                bcd_q   <= scr_q;
                blank_q <= blank_d;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;

endmodule
